// File: rtl/instr_mem_if.sv
// Fetch and programming bus between the PC/decode stages, the boot loader and instr_mem_ctrl.
interface instr_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              prog_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_err;
    logic              prog_mode;
    logic              fetch_req;
    logic [ADDR_W-1:0] pc;
    logic              fetch_gnt;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              addr_fault;

    modport master (
        output prog_en, prog_we, prog_addr, prog_data, fetch_req, pc, instr_ready,
        input  prog_err, prog_mode, fetch_gnt, instr, instr_valid, addr_fault
    );

    modport slave (
        input  prog_en, prog_we, prog_addr, prog_data, fetch_req, pc, instr_ready,
        output prog_err, prog_mode, fetch_gnt, instr, instr_valid, addr_fault
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Runtime-programmable instruction memory: one-cycle fetch with back-pressure,
// a programming mode entered only once the output slot has drained, and range faults.
module instr_mem_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
    input logic        clk,
    input logic        reset_n,
    instr_mem_if.slave bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PROG  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic              slot_free;
    logic              gnt;
    logic              wr_ok;
    logic              wr_bad;
    logic [DATA_W-1:0] instr_p0;
    logic              fault_p0;
    logic [DATA_W-1:0] instr_p1;
    logic              fault_p1;
    logic              vld_p1;
    logic              prog_err_p1;

    // Full-width compare: addresses never wrap onto the array.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    assign slot_free = !vld_p1 || bus.instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = 1'b0;
        wr_ok     = 1'b0;
        wr_bad    = 1'b0;
        case (state)
            RUN: begin
                if (bus.prog_en) state_nxt = slot_free ? PROG : DRAIN;
                else             gnt       = bus.fetch_req && slot_free;
            end
            DRAIN: begin
                if (!bus.prog_en)         state_nxt = RUN;
                else if (bus.instr_ready) state_nxt = PROG;
            end
            PROG: begin
                if (!bus.prog_en) begin
                    state_nxt = RUN;
                end else if (bus.prog_we) begin
                    wr_ok  = in_range(bus.prog_addr);
                    wr_bad = !in_range(bus.prog_addr);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[bus.prog_addr[IDX_W-1:0]] <= bus.prog_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            written     <= '0;
            prog_err_p1 <= 1'b0;
        end else begin
            prog_err_p1 <= wr_bad;
            if (wr_ok) written[bus.prog_addr[IDX_W-1:0]] <= 1'b1;
        end
    end

    // p0: array lookup, unwritten or out-of-range entries read as NOP_WORD
    always_comb begin
        fault_p0 = !in_range(bus.pc);
        instr_p0 = NOP_WORD;
        if (!fault_p0 && written[bus.pc[IDX_W-1:0]]) instr_p0 = mem[bus.pc[IDX_W-1:0]];
    end

    // p1: output slot, refilled on grant and emptied on consume
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_p1 <= NOP_WORD;
            fault_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (gnt) begin
            instr_p1 <= instr_p0;
            fault_p1 <= fault_p0;
            vld_p1   <= 1'b1;
        end else if (bus.instr_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.fetch_gnt   = gnt;
    assign bus.instr       = instr_p1;
    assign bus.addr_fault  = fault_p1;
    assign bus.instr_valid = vld_p1;
    assign bus.prog_err    = prog_err_p1;
    assign bus.prog_mode   = (state == PROG);
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed fetch table, corner-case sequences and a randomized
// run against a cycle-level reference model.
module tb_instr_mem_ctrl;
    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 8;
    localparam logic [15:0] NOP    = 16'hF00F;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    instr_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    instr_mem_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[9];

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    bit          m_valid;
    logic [15:0] m_instr;
    bit          m_fault;
    bit          m_err;
    bit          m_prog;
    bit          m_drain;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.prog_en     = 1'b0;
        bus.prog_we     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;
        bus.fetch_req   = 1'b0;
        bus.pc          = '0;
        bus.instr_ready = 1'b0;
    endtask

    task automatic write(input logic [7:0] a, input logic [15:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        chk1("write_no_err", bus.prog_err, 1'b0);
    endtask

    task automatic fetch_check(input string name, input logic [7:0] p,
                               input logic [15:0] ei, input logic ef);
        bus.pc          = p;
        bus.fetch_req   = 1'b1;
        bus.instr_ready = 1'b1;
        #1;
        chk1({name, "_gnt"}, bus.fetch_gnt, 1'b1);
        tick();
        chk16({name, "_instr"}, bus.instr, ei);
        chk1({name, "_fault"}, bus.addr_fault, ef);
        chk1({name, "_valid"}, bus.instr_valid, 1'b1);
    endtask

    initial begin
        bit          sfree;
        bit          g;
        bit          run;
        bit          inr;
        logic [15:0] word;

        vecs[0] = '{8'd0,   16'h489A, 1'b0};
        vecs[1] = '{8'd1,   16'h2D05, 1'b0};
        vecs[2] = '{8'd2,   NOP,      1'b0};
        vecs[3] = '{8'd3,   16'h1234, 1'b0};
        vecs[4] = '{8'd7,   16'h7777, 1'b0};
        vecs[5] = '{8'd8,   NOP,      1'b1};
        vecs[6] = '{8'd9,   NOP,      1'b1};
        vecs[7] = '{8'd255, NOP,      1'b1};
        vecs[8] = '{8'd6,   NOP,      1'b0};

        idle();
        reset_n = 1'b0;
        #12;
        chk16("rst_instr", bus.instr, NOP);
        chk1("rst_valid", bus.instr_valid, 1'b0);
        chk1("rst_fault", bus.addr_fault, 1'b0);
        chk1("rst_prog_err", bus.prog_err, 1'b0);
        chk1("rst_prog_mode", bus.prog_mode, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Program, including an overwrite of address 3
        bus.prog_en = 1'b1;
        tick();
        chk1("enter_prog", bus.prog_mode, 1'b1);
        write(8'd0, 16'h489A);
        write(8'd1, 16'h2D05);
        write(8'd3, 16'hABCD);
        write(8'd7, 16'h7777);
        write(8'd3, 16'h1234);
        bus.prog_we = 1'b0;
        bus.prog_en = 1'b0;
        tick();
        chk1("exit_prog", bus.prog_mode, 1'b0);

        // Back-to-back fetches from the table
        for (int i = 0; i < 9; i++) fetch_check($sformatf("vec%0d", i), vecs[i].pc,
                                                vecs[i].exp_instr, vecs[i].exp_fault);

        // Stall holding 489A, then release with a same-cycle grant
        fetch_check("stall_fill", 8'd0, 16'h489A, 1'b0);
        bus.instr_ready = 1'b0;
        bus.pc = 8'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_gnt", bus.fetch_gnt, 1'b0);
            tick();
            chk16("stall_instr", bus.instr, 16'h489A);
            chk1("stall_valid", bus.instr_valid, 1'b1);
        end
        fetch_check("stall_release", 8'd1, 16'h2D05, 1'b0);

        // prog_en during a stall drains before entering PROG
        bus.instr_ready = 1'b0;
        bus.pc = 8'd0;
        bus.prog_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk1("drain_gnt", bus.fetch_gnt, 1'b0);
            tick();
            chk1("drain_mode", bus.prog_mode, 1'b0);
            chk1("drain_valid", bus.instr_valid, 1'b1);
            chk16("drain_instr", bus.instr, 16'h2D05);
        end
        bus.instr_ready = 1'b1;
        #1;
        chk1("drain_consume_gnt", bus.fetch_gnt, 1'b0);
        tick();
        chk1("drain_to_prog", bus.prog_mode, 1'b1);
        chk1("drain_delivered_once", bus.instr_valid, 1'b0);
        tick();
        chk1("prog_no_refill", bus.instr_valid, 1'b0);

        // Out-of-range write, then writes outside PROG
        bus.fetch_req = 1'b0;
        bus.prog_we = 1'b1;
        bus.prog_addr = 8'd9;
        bus.prog_data = 16'hFFFF;
        tick();
        chk1("oor_err_pulse", bus.prog_err, 1'b1);
        bus.prog_we = 1'b0;
        tick();
        chk1("oor_err_clear", bus.prog_err, 1'b0);
        bus.prog_en = 1'b0;
        bus.prog_we = 1'b1;
        bus.prog_addr = 8'd2;
        bus.prog_data = 16'h5555;
        tick();
        chk1("exit_we_no_err", bus.prog_err, 1'b0);
        chk1("exit_we_mode", bus.prog_mode, 1'b0);
        bus.prog_addr = 8'd4;
        bus.prog_data = 16'h4444;
        tick();
        chk1("run_we_no_err", bus.prog_err, 1'b0);
        bus.prog_we = 1'b0;
        fetch_check("exit_we_ignored", 8'd2, NOP, 1'b0);
        fetch_check("run_we_ignored", 8'd4, NOP, 1'b0);
        fetch_check("oor_mem_intact", 8'd1, 16'h2D05, 1'b0);

        // Asynchronous reset in the middle of PROG
        bus.prog_en = 1'b1;
        tick();
        chk1("reprog_mode", bus.prog_mode, 1'b1);
        write(8'd0, 16'h1111);
        #3;
        reset_n = 1'b0;
        idle();
        #1;
        chk1("rst_prog_mode_now", bus.prog_mode, 1'b0);
        chk1("rst_prog_valid_now", bus.instr_valid, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        fetch_check("after_rst_nop", 8'd0, NOP, 1'b0);

        // Asynchronous reset during a stall
        bus.fetch_req = 1'b0;
        bus.prog_en = 1'b1;
        tick();
        write(8'd5, 16'hABCD);
        bus.prog_we = 1'b0;
        bus.prog_en = 1'b0;
        tick();
        fetch_check("pre_stall", 8'd5, 16'hABCD, 1'b0);
        bus.instr_ready = 1'b0;
        bus.fetch_req = 1'b0;
        tick();
        chk1("stall_hold_valid", bus.instr_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("rst_stall_valid_now", bus.instr_valid, 1'b0);
        chk16("rst_stall_instr_now", bus.instr, NOP);
        idle();
        tick();
        reset_n = 1'b1;
        tick();
        fetch_check("after_rst2_nop", 8'd5, NOP, 1'b0);

        // Randomized run against the reference model, from a fresh reset
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m_wr[i]  = 1'b0;
            m_mem[i] = '0;
        end
        m_valid = 1'b0;
        m_instr = NOP;
        m_fault = 1'b0;
        m_err   = 1'b0;
        m_prog  = 1'b0;
        m_drain = 1'b0;
        tick();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) bus.prog_en = !bus.prog_en;
            bus.prog_we     = 1'($urandom_range(0, 1));
            bus.prog_addr   = 8'($urandom_range(0, 11));
            bus.prog_data   = 16'($urandom);
            bus.fetch_req   = ($urandom_range(0, 3) != 0);
            bus.pc          = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            #1;

            run   = !m_prog && !m_drain;
            sfree = !m_valid || bus.instr_ready;
            g     = run && !bus.prog_en && bus.fetch_req && sfree;
            chk1("rnd_gnt", bus.fetch_gnt, g);

            inr  = int'(bus.pc) < DEPTH;
            word = (inr && m_wr[int'(bus.pc)]) ? m_mem[int'(bus.pc)] : NOP;
            m_err = m_prog && bus.prog_en && bus.prog_we && (int'(bus.prog_addr) >= DEPTH);
            if (m_prog && bus.prog_en && bus.prog_we && int'(bus.prog_addr) < DEPTH) begin
                m_mem[int'(bus.prog_addr)] = bus.prog_data;
                m_wr[int'(bus.prog_addr)]  = 1'b1;
            end
            if (g) begin
                m_valid = 1'b1;
                m_instr = word;
                m_fault = !inr;
            end else if (bus.instr_ready) begin
                m_valid = 1'b0;
            end
            if (run) begin
                if (bus.prog_en) begin
                    m_prog  = sfree;
                    m_drain = !sfree;
                end
            end else if (m_drain) begin
                if (!bus.prog_en) m_drain = 1'b0;
                else if (bus.instr_ready) begin
                    m_drain = 1'b0;
                    m_prog  = 1'b1;
                end
            end else if (!bus.prog_en) begin
                m_prog = 1'b0;
            end

            tick();
            chk1("rnd_valid", bus.instr_valid, m_valid);
            chk16("rnd_instr", bus.instr, m_instr);
            chk1("rnd_fault", bus.addr_fault, m_fault);
            chk1("rnd_prog_mode", bus.prog_mode, m_prog);
            chk1("rnd_prog_err", bus.prog_err, m_err);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
